ctrl_seq: RTL and testbench

- Multi-cycle, parametrised successor to the single-cycle controller.
- Accepts instructions over a valid/ready handshake and latches each one, then sequences it through a small FSM.
- ALU instructions get a timed enable window. Memory instructions get a request/acknowledge cycle with a timeout.
- Sits between the instruction fetch path and the ALU / register file / memory interface; drives the same decoded fields, now registered.

---
 rtl/ctrl_seq_pkg.sv | 38 +++
 rtl/ctrl_timer.sv | 30 +++
 rtl/ctrl_seq.sv | 142 ++++++++++++++
 tb/tb_ctrl_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the multi-cycle instruction controller:
// memory opcodes, arithmetic-class bit, FSM state encodings, timer sizing.
package ctrl_seq_pkg;

    // Memory opcodes. Both have the arithmetic bit set, so the classifier
    // must test them before the arithmetic bit.
    localparam logic [3:0] OPCODE_LDB = 4'hA;
    localparam logic [3:0] OPCODE_STB = 4'hB;

    // Opcode bit that separates ALU (clear) from NOP class (set).
    localparam int unsigned OPCODE_ARITHMETIC_BIT = 3;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] CTRL_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] CTRL_DECODE = 3'd1;
    localparam logic [STATE_W-1:0] CTRL_ALU    = 3'd2;
    localparam logic [STATE_W-1:0] CTRL_MEM    = 3'd3;
    localparam logic [STATE_W-1:0] CTRL_DONE   = 3'd4;
    localparam logic [STATE_W-1:0] CTRL_ERR    = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = CTRL_IDLE,
        ST_DECODE = CTRL_DECODE,
        ST_ALU    = CTRL_ALU,
        ST_MEM    = CTRL_MEM,
        ST_DONE   = CTRL_DONE,
        ST_ERR    = CTRL_ERR
    } ctrl_state_e;

    // Counter width able to hold max(a, b) - 1; never narrower than 1 bit.
    function automatic int unsigned timer_width(int unsigned a, int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/ctrl_timer.sv
// Loadable down-counter with terminal-count flag; shared by the ALU enable
// window and the memory-acknowledge timeout.
// Ports: clk, rst (sync, active-high), load/load_val (preset),
//        tc_c (count is zero, decoded from the count register).
module ctrl_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc_c
);

    logic [W-1:0] count;

    // Preset on load, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc_c = (count == '0);

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle instruction controller. Accepts one instruction over a
// valid/ready handshake, latches it, and sequences it through
// IDLE -> DECODE -> {ALU | MEM | DONE} -> {DONE | ERR} -> IDLE.
// Ports: clk, rst (sync, active-high); instr/instr_valid/instr_ready
//        handshake; mem_ack from memory; alu_op/alu_shamt/alu_en to the
//        ALU; fetch/we memory request; nibble_out/reg_sel/reg16_src/
//        reg16_dst decoded operand fields; done/mem_err retire strobes.
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 4,
    parameter int unsigned OPERAND_W   = 4,
    parameter int unsigned ALU_CYCLES  = 1,
    parameter int unsigned MEM_TIMEOUT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [OPCODE_W+OPERAND_W-1:0] instr,
    input  logic                          instr_valid,
    output logic                          instr_ready,
    input  logic                          mem_ack,
    output logic [2:0]                    alu_op,
    output logic [2:0]                    alu_shamt,
    output logic                          alu_en,
    output logic                          fetch,
    output logic                          we,
    output logic [OPERAND_W-1:0]          nibble_out,
    output logic [OPERAND_W-1:0]          reg_sel,
    output logic [OPERAND_W/2-1:0]        reg16_src,
    output logic [OPERAND_W/2-1:0]        reg16_dst,
    output logic                          done,
    output logic                          mem_err
);

    localparam int unsigned INSTR_W = OPCODE_W + OPERAND_W;
    localparam int unsigned HALF_W  = OPERAND_W / 2;
    localparam int unsigned TMR_W   = timer_width(ALU_CYCLES, MEM_TIMEOUT);

    ctrl_state_e          state;
    ctrl_state_e          state_next;
    logic [INSTR_W-1:0]   instr_q;
    logic [OPCODE_W-1:0]  opcode;
    logic [OPERAND_W-1:0] operand;
    logic                 is_ldb_c;
    logic                 is_stb_c;
    logic                 is_alu_c;
    logic                 tmr_load_c;
    logic [TMR_W-1:0]     tmr_val_c;
    logic                 tmr_tc_c;

    assign opcode  = instr_q[INSTR_W-1 -: OPCODE_W];
    assign operand = instr_q[OPERAND_W-1:0];

    // Classification of the latched opcode.
    assign is_ldb_c = (opcode == OPCODE_W'(OPCODE_LDB));
    assign is_stb_c = (opcode == OPCODE_W'(OPCODE_STB));
    assign is_alu_c = !opcode[OPCODE_ARITHMETIC_BIT];

    ctrl_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .tc_c     (tmr_tc_c)
    );

    // Next-state logic; the timer is preset in DECODE for whichever
    // phase follows, so it reads zero on the last ALU / MEM cycle.
    always_comb begin
        state_next = ST_IDLE;
        tmr_load_c = 1'b0;
        tmr_val_c  = TMR_W'(ALU_CYCLES - 1);
        case (state)
            ST_IDLE: begin
                state_next = instr_valid ? ST_DECODE : ST_IDLE;
            end
            ST_DECODE: begin
                tmr_load_c = 1'b1;
                if (is_ldb_c || is_stb_c) begin
                    state_next = ST_MEM;
                    tmr_val_c  = TMR_W'(MEM_TIMEOUT - 1);
                end else if (is_alu_c) begin
                    state_next = ST_ALU;
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_ALU: begin
                state_next = tmr_tc_c ? ST_DONE : ST_ALU;
            end
            ST_MEM: begin
                // Acknowledge wins over a simultaneous timeout.
                if (mem_ack) begin
                    state_next = ST_DONE;
                end else if (tmr_tc_c) begin
                    state_next = ST_ERR;
                end else begin
                    state_next = ST_MEM;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_ERR:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State, instruction latch and registered outputs (decoded from next state).
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            instr_q     <= '0;
            instr_ready <= 1'b1;
            alu_en      <= 1'b0;
            fetch       <= 1'b0;
            we          <= 1'b0;
            done        <= 1'b0;
            mem_err     <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && instr_valid) begin
                instr_q <= instr;
            end
            instr_ready <= (state_next == ST_IDLE);
            alu_en      <= (state_next == ST_ALU);
            fetch       <= (state_next == ST_MEM);
            we          <= (state_next == ST_MEM) && is_stb_c;
            done        <= (state_next == ST_DONE);
            mem_err     <= (state_next == ST_ERR);
        end
    end

    // Operand fields straight from the latch; stable until the next accept.
    assign alu_op     = opcode[2:0];
    assign alu_shamt  = operand[2:0];
    assign nibble_out = operand;
    assign reg_sel    = operand;
    assign reg16_src  = operand[OPERAND_W-1 -: HALF_W];
    assign reg16_dst  = operand[HALF_W-1:0];

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq (ALU_CYCLES=3, MEM_TIMEOUT=8). Stimulus
// pushes the expected retirement of each instruction; a negedge monitor
// tracks the handshake and pops/compares on every done or mem_err strobe.
module tb_ctrl_seq;

    logic       clk;
    logic       rst;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic       mem_ack;
    logic [2:0] alu_op;
    logic [2:0] alu_shamt;
    logic       alu_en;
    logic       fetch;
    logic       we;
    logic [3:0] nibble_out;
    logic [3:0] reg_sel;
    logic [1:0] reg16_src;
    logic [1:0] reg16_dst;
    logic       done;
    logic       mem_err;

    ctrl_seq #(
        .OPCODE_W    (4),
        .OPERAND_W   (4),
        .ALU_CYCLES  (3),
        .MEM_TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .mem_ack     (mem_ack),
        .alu_op      (alu_op),
        .alu_shamt   (alu_shamt),
        .alu_en      (alu_en),
        .fetch       (fetch),
        .we          (we),
        .nibble_out  (nibble_out),
        .reg_sel     (reg_sel),
        .reg16_src   (reg16_src),
        .reg16_dst   (reg16_dst),
        .done        (done),
        .mem_err     (mem_err)
    );

    typedef struct {
        bit is_err;
        int lat;
        int alu;
        int fetch;
        int we;
        int first;
        int op;
        int shamt;
        int src;
        int dst;
        int sel;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   alu_cnt  = 0;
    int   fetch_cnt = 0;
    int   we_cnt   = 0;
    int   act_first = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic exp_t mk(bit is_err, int lat, int alu, int fc, int wc, int first,
                                int op, int shamt, int src, int dst, int sel);
        exp_t e;
        e.is_err = is_err; e.lat = lat; e.alu = alu; e.fetch = fc; e.we = wc;
        e.first = first; e.op = op; e.shamt = shamt; e.src = src; e.dst = dst; e.sel = sel;
        return e;
    endfunction

    // Monitor: handshake tracking, activity counting, retirement checks.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && instr_ready && instr_valid) begin
            acc_cyc   = cyc;
            alu_cnt   = 0;
            fetch_cnt = 0;
            we_cnt    = 0;
            act_first = -1;
        end else begin
            if (alu_en) alu_cnt++;
            if (fetch)  fetch_cnt++;
            if (we)     we_cnt++;
            if ((alu_en || fetch) && act_first < 0) act_first = cyc - acc_cyc;
        end
        if (done || mem_err) begin
            if (sb.size() == 0) begin
                chk("unexpected_retire", int'(done) + int'(mem_err), 0);
            end else begin
                e = sb.pop_front();
                chk("retire_done",    int'(done),        int'(!e.is_err));
                chk("retire_mem_err", int'(mem_err),     int'(e.is_err));
                chk("latency",        cyc - acc_cyc,     e.lat);
                chk("alu_en_cycles",  alu_cnt,           e.alu);
                chk("fetch_cycles",   fetch_cnt,         e.fetch);
                chk("we_cycles",      we_cnt,            e.we);
                chk("first_active",   act_first,         e.first);
                chk("alu_op",         int'(alu_op),      e.op);
                chk("alu_shamt",      int'(alu_shamt),   e.shamt);
                chk("reg16_src",      int'(reg16_src),   e.src);
                chk("reg16_dst",      int'(reg16_dst),   e.dst);
                chk("reg_sel",        int'(reg_sel),     e.sel);
                chk("nibble_out",     int'(nibble_out),  e.sel);
            end
        end
    end

    // Present an instruction (controller must be idle), push its expectation.
    task automatic issue(input logic [7:0] ins, input exp_t e);
        int g = 0;
        @(posedge clk); #1;
        instr       = ins;
        instr_valid = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        while (!instr_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("issue_ready", int'(instr_ready), 1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr       = 8'hFF;
    endtask

    // Pulse mem_ack during the k-th MEM cycle; call right after issue().
    task automatic ack_on(input int k);
        repeat (k) @(posedge clk);
        #1 mem_ack = 1'b1;
        @(posedge clk);
        #1 mem_ack = 1'b0;
    endtask

    task automatic wait_retire(input string name);
        int g = 0;
        @(negedge clk);
        while (!(done || mem_err) && g < 60) begin
            @(negedge clk);
            g++;
        end
        chk({name, "_retired"}, int'(done || mem_err), 1);
        @(negedge clk);
        chk({name, "_ready_after"}, int'(instr_ready), 1);
        chk({name, "_strobe_1cyc"}, int'(done || mem_err), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        instr       = 8'h00;
        instr_valid = 1'b0;
        mem_ack     = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_instr_ready", int'(instr_ready), 1);
        chk("rst_alu_en",      int'(alu_en),      0);
        chk("rst_fetch",       int'(fetch),       0);
        chk("rst_we",          int'(we),          0);
        chk("rst_done",        int'(done),        0);
        chk("rst_mem_err",     int'(mem_err),     0);
        chk("rst_reg_sel",     int'(reg_sel),     0);
        chk("rst_alu_op",      int'(alu_op),      0);
        @(posedge clk); #1 rst = 1'b0;

        // ALU ops: exactly 3 enable cycles, done 5 cycles after accept.
        issue(8'h25, mk(0, 5, 3, 0, 0, 2, 2, 5, 1, 1, 5));
        wait_retire("alu_25");
        issue(8'h7F, mk(0, 5, 3, 0, 0, 2, 7, 7, 3, 3, 15));
        wait_retire("alu_7f");

        // STB acked on the 2nd MEM cycle.
        issue(8'hBD, mk(0, 4, 0, 2, 2, 2, 3, 5, 3, 1, 13));
        ack_on(2);
        wait_retire("stb_ack2");

        // LDB, ack only during DECODE (ignored), then timeout abort.
        issue(8'hA6, mk(1, 10, 0, 8, 0, 2, 2, 6, 1, 2, 6));
        mem_ack = 1'b1;
        @(posedge clk); #1 mem_ack = 1'b0;
        wait_retire("ldb_timeout");

        // Ack on the final timeout cycle: ack wins.
        issue(8'hA3, mk(0, 10, 0, 8, 0, 2, 2, 3, 0, 3, 3));
        ack_on(8);
        wait_retire("ldb_collision");

        // NOP class, including an opcode with all bits set.
        issue(8'h89, mk(0, 2, 0, 0, 0, -1, 0, 1, 2, 1, 9));
        wait_retire("nop_89");
        issue(8'hF2, mk(0, 2, 0, 0, 0, -1, 7, 2, 0, 2, 2));
        wait_retire("nop_f2");

        // ALU op with mem_ack high throughout: ack ignored outside MEM.
        issue(8'h00, mk(0, 5, 3, 0, 0, 2, 0, 0, 0, 0, 0));
        mem_ack = 1'b1;
        repeat (4) @(posedge clk);
        #1 mem_ack = 1'b0;
        wait_retire("alu_ack_ignored");

        // STB acked on the first MEM cycle.
        issue(8'hB1, mk(0, 3, 0, 1, 1, 2, 3, 1, 0, 1, 1));
        ack_on(1);
        wait_retire("stb_ack1");

        // Reset on the 3rd fetch cycle of an STB (no expectation pushed).
        @(posedge clk); #1;
        instr       = 8'hB4;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst         = 1'b1;
        instr       = 8'h51;
        instr_valid = 1'b1;
        @(negedge clk);
        chk("pre_rst_fetch", int'(fetch), 1);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_fetch",   int'(fetch),       0);
        chk("midrst_we",      int'(we),          0);
        chk("midrst_done",    int'(done),        0);
        chk("midrst_mem_err", int'(mem_err),     0);
        chk("midrst_ready",   int'(instr_ready), 1);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_alu_en", int'(alu_en),      0);
        chk("rst_hold_ready",  int'(instr_ready), 1);
        sb.push_back(mk(0, 5, 3, 0, 0, 2, 5, 1, 0, 1, 1));
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr       = 8'hFF;
        wait_retire("post_rst_alu");

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
